instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  IF stage: owns the PC, fetches one 32-bit word per accepted imem handshake and drives the
//  IF/ID register (instr_out, pipe_pc_out) feeding instruction_decode data_in/pipe_pc_in.
//  Handles hazard stall, taken-branch/jump redirect, and generates the one-cycle squash that
//  drives decode's succ input.
// PARAMETERS
//  RESET_PC  32'h00400000  PC after reset; also pipe_pc_out reset value
//  NOP_INSTR 32'h00000013  addi x0,x0,0; bubble word presented when instr_valid=0
// PORTS
//  clock          in   1   single clock, all state on posedge
//  reset          in   1   synchronous, active-high
//  stall          in   1   hazard unit: hold IF/ID outputs and PC
//  redirect_valid in   1   branch/jump resolved taken this cycle
//  redirect_pc    in   32  target PC; bits [1:0] ignored (forced 0)
//  imem_req       out  1   fetch request
//  imem_addr      out  32  fetch address (= pc)
//  imem_ready     in   1   word valid on imem_rdata this cycle (handshake when req&ready)
//  imem_rdata     in   32  fetched word
//  instr_out      out  32  IF/ID instruction -> decode data_in
//  pipe_pc_out    out  32  PC of instr_out -> decode pipe_pc_in
//  instr_valid    out  1   instr_out is real (not a bubble)
//  squash_out     out  1   to decode succ; 1 for exactly one cycle after a redirect
// BEHAVIOUR
//  Reset (sync, checked first): pc=RESET_PC, state=FETCH, instr_out=NOP_INSTR,
//   pipe_pc_out=RESET_PC, instr_valid=0, squash_out=0, hold buffer empty. imem_req is 0
//   during any cycle in which reset=1.
//  imem protocol: imem_req/imem_addr are combinational from state/pc; no commitment until
//   imem_ready; addr may change while waiting (no outstanding-request tracking). Words
//   returned with req=0 are ignored.
//  States:
//   FETCH: imem_req=1, imem_addr=pc.
//    ready&~stall -> instr_out=rdata, pipe_pc_out=pc, instr_valid=1, pc+=4; stay FETCH.
//    ready&stall  -> word+pc into hold buffer, pc+=4, outputs unchanged; go HOLD.
//    ~ready&~stall-> instr_out=NOP_INSTR, instr_valid=0, pipe_pc_out unchanged.
//    ~ready&stall -> outputs unchanged.
//   HOLD: imem_req=0. ~stall -> outputs load hold buffer, instr_valid=1; go FETCH. stall -> wait.
//  Redirect (priority over stall and imem_ready, any state): pc<=redirect_pc&~3; hold buffer
//   dropped; word accepted that cycle discarded; instr_out=NOP_INSTR, instr_valid=0,
//   pipe_pc_out unchanged; squash_out=1 next cycle only; state=FETCH. Back-to-back redirects
//   keep squash_out high; last target wins.
//  Stall holds instr_out/pipe_pc_out/instr_valid exactly, including during a bubble.
//  Arithmetic: pc+4 modulo 2^32 (0xFFFFFFFC -> 0x00000000), no flag.
//  Latency: word accepted in cycle N (not stalled) appears on instr_out at N+1.
//  Throughput: one instruction/cycle when imem_ready=1 and stall=0.
// STRUCTURE
//  Shared package rv_pkg: RESET_PC, NOP_INSTR, XLEN=32, fetch-state encoding (FETCH, HOLD).
//  One sub-module: fetch_hold_buf (1-entry word+PC register, load/clear/valid); rest inline.
// TESTING
//  1 reset held 3 cycles, ready=1 -> imem_req=0 during reset; then addr 0x00400000,
//    0x00400004, 0x00400008 on consecutive cycles; instr_out follows one cycle later.
//  2 ready low 2 cycles at pc=0x00400008 -> two bubbles (NOP_INSTR, valid=0),
//    pipe_pc_out stays 0x00400004; word appears with pipe_pc_out=0x00400008.
//  3 stall=1 for 3 cycles while ready=1 -> outputs frozen, one word buffered, req=0 in HOLD;
//    on release buffered word emitted, next fetch addr = buffered pc+4, no loss/duplication.
//  4 redirect_pc=0x00400103 while in HOLD with stall=1 -> buffer dropped, addr 0x00400100
//    next cycle, squash_out=1 exactly one cycle, instr_valid=0.
//  5 redirect and ready same cycle -> accepted word discarded, never on instr_out.
//  6 redirect to 0xFFFFFFFC, ready=1 -> fetch 0xFFFFFFFC then 0x00000000.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared constants and fetch-state encoding for the IF stage.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0040_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry word+PC buffer capturing a fetched word that arrived while decode was stalled.
module fetch_hold_buf
  import rv_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] word_in,
  input  logic [XLEN-1:0] pc_in,
  output logic            valid,
  output logic [XLEN-1:0] word,
  output logic [XLEN-1:0] pc
);

  logic            valid_q;
  logic [XLEN-1:0] word_q;
  logic [XLEN-1:0] pc_q;

  // Clear wins over load so a redirect always drops a word captured in the same cycle.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      valid_q <= 1'b0;
      word_q  <= NOP_INSTR;
      pc_q    <= RESET_PC;
    end else if (load) begin
      valid_q <= 1'b1;
      word_q  <= word_in;
      pc_q    <= pc_in;
    end
  end

  assign valid = valid_q;
  assign word  = word_q;
  assign pc    = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, fetches over a req/ready handshake and drives the IF/ID register,
// with stall hold, redirect and a one-cycle squash toward decode.
module instruction_fetch
  import rv_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pipe_pc_out,
  output logic            instr_valid,
  output logic            squash_out
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pipe_pc_q, pipe_pc_d;
  logic            valid_q, valid_d;
  logic            squash_q, squash_d;

  logic            buf_load;
  logic            buf_clear;
  logic            buf_valid;
  logic [XLEN-1:0] buf_word;
  logic [XLEN-1:0] buf_pc;
  logic            accept;

  fetch_hold_buf u_hold_buf (
    .clock   (clock),
    .reset   (reset),
    .load    (buf_load),
    .clear   (buf_clear),
    .word_in (imem_rdata),
    .pc_in   (pc_q),
    .valid   (buf_valid),
    .word    (buf_word),
    .pc      (buf_pc)
  );

  assign imem_req  = ~reset & (state_q == FETCH);
  assign imem_addr = pc_q;
  assign accept    = imem_req & imem_ready;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    pipe_pc_d = pipe_pc_q;
    valid_d   = valid_q;
    squash_d  = 1'b0;
    buf_load  = 1'b0;
    buf_clear = 1'b0;

    if (redirect_valid) begin
      // Redirect overrides stall and any word returned this cycle.
      state_d   = FETCH;
      pc_d      = {redirect_pc[XLEN-1:2], 2'b00};
      instr_d   = NOP_INSTR;
      valid_d   = 1'b0;
      squash_d  = 1'b1;
      buf_clear = 1'b1;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (accept) begin
            pc_d = pc_q + 32'd4;
            if (stall) begin
              buf_load = 1'b1;
              state_d  = HOLD;
            end else begin
              instr_d   = imem_rdata;
              pipe_pc_d = pc_q;
              valid_d   = 1'b1;
            end
          end else if (!stall) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_d   = buf_word;
            pipe_pc_d = buf_pc;
            valid_d   = buf_valid;
            buf_clear = 1'b1;
            state_d   = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      pipe_pc_q <= RESET_PC;
      valid_q   <= 1'b0;
      squash_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pipe_pc_q <= pipe_pc_d;
      valid_q   <= valid_d;
      squash_q  <= squash_d;
    end
  end

  assign instr_out   = instr_q;
  assign pipe_pc_out = pipe_pc_q;
  assign instr_valid = valid_q;
  assign squash_out  = squash_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios then random traffic against a behavioural model.
module tb_instruction_fetch;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr_out;
  logic [31:0] pipe_pc_out;
  logic        instr_valid;
  logic        squash_out;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Behavioural model: architectural PC, IF/ID outputs and an optional parked word.
  logic        m_init = 1'b0;
  logic [31:0] m_pc, m_instr, m_ppc, m_bword, m_bpc;
  logic        m_valid, m_squash;
  logic        m_parked = 1'b0;

  instruction_fetch dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .instr_out      (instr_out),
    .pipe_pc_out    (pipe_pc_out),
    .instr_valid    (instr_valid),
    .squash_out     (squash_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  // Apply inputs shortly after the falling edge; outputs are then stable for checking.
  task automatic drive(input logic rst, input logic st, input logic rv, input logic [31:0] rpc,
                       input logic rdy, input logic [31:0] data);
    reset          = rst;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_ready     = rdy;
    imem_rdata     = data;
    #1;
  endtask

  task automatic model_step();
    if (reset) begin
      m_init = 1'b1; m_pc = RST_PC; m_instr = NOP; m_ppc = RST_PC;
      m_valid = 1'b0; m_squash = 1'b0; m_parked = 1'b0;
    end else if (redirect_valid) begin
      m_pc = redirect_pc & 32'hFFFF_FFFC; m_parked = 1'b0;
      m_instr = NOP; m_valid = 1'b0; m_squash = 1'b1;
    end else begin
      m_squash = 1'b0;
      if (m_parked) begin
        if (!stall) begin
          m_instr = m_bword; m_ppc = m_bpc; m_valid = 1'b1; m_parked = 1'b0;
        end
      end else if (imem_ready) begin
        if (stall) begin
          m_bword = imem_rdata; m_bpc = m_pc; m_parked = 1'b1;
        end else begin
          m_instr = imem_rdata; m_ppc = m_pc; m_valid = 1'b1;
        end
        m_pc = m_pc + 32'd4;
      end else if (!stall) begin
        m_instr = NOP; m_valid = 1'b0;
      end
    end
  endtask

  // Compare everything against the model, then clock once and advance the model.
  task automatic finish_cycle();
    logic exp_req;
    exp_req = !reset && m_init && !m_parked;
    if (reset) exp_req = 1'b0;
    check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    if (m_init) begin
      if (exp_req) check("imem_addr", imem_addr, m_pc);
      check("instr_out", instr_out, m_instr);
      check("pipe_pc_out", pipe_pc_out, m_ppc);
      check("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
      check("squash_out", {31'd0, squash_out}, {31'd0, m_squash});
    end
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic step(input logic rst, input logic st, input logic rv, input logic [31:0] rpc,
                      input logic rdy);
    drive(rst, st, rv, rpc, rdy, mem_word(m_init ? m_pc : RST_PC));
    finish_cycle();
  endtask

  initial begin
    @(negedge clock);
    // Reset held three cycles with ready high: no request may issue.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 32'hFFFF_FFFF);
      check("req_in_reset", {31'd0, imem_req}, 32'd0);
      finish_cycle();
    end
    check("reset_instr", instr_out, NOP);
    check("reset_pipe_pc", pipe_pc_out, RST_PC);

    // Straight-line fetch.
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, mem_word(32'h0040_0000));
    check("addr0", imem_addr, 32'h0040_0000);
    finish_cycle();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, mem_word(32'h0040_0004));
    check("addr1", imem_addr, 32'h0040_0004);
    check("first_word", instr_out, mem_word(32'h0040_0000));
    finish_cycle();

    // Two not-ready cycles at 0x00400008 produce two bubbles.
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 32'h0);
    check("bubble_valid", {31'd0, instr_valid}, 32'd0);
    check("bubble_ppc", pipe_pc_out, 32'h0040_0004);
    finish_cycle();
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("after_bubble_ppc", pipe_pc_out, 32'h0040_0008);

    // Stall three cycles with ready high: one word parked, requests drop.
    step(1'b0, 1'b1, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, '0, 1'b1, 32'hBAD0_0001);
    check("hold_no_req", {31'd0, imem_req}, 32'd0);
    finish_cycle();
    step(1'b0, 1'b1, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("held_word_ppc", pipe_pc_out, 32'h0040_000C);
    check("held_word", instr_out, mem_word(32'h0040_000C));
    check("resume_addr", imem_addr, 32'h0040_0010);

    // Redirect while parked with stall high drops the parked word.
    step(1'b0, 1'b1, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 32'h0040_0103, 1'b1);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 32'h0);
    check("redir_addr", imem_addr, 32'h0040_0100);
    check("redir_squash", {31'd0, squash_out}, 32'd1);
    check("redir_valid", {31'd0, instr_valid}, 32'd0);
    finish_cycle();
    check("squash_once", {31'd0, squash_out}, 32'd0);

    // Redirect coinciding with an accepted word discards that word.
    drive(1'b0, 1'b0, 1'b1, 32'h0040_0200, 1'b1, 32'hDEAD_BEEF);
    finish_cycle();
    check("discard_valid", {31'd0, instr_valid}, 32'd0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("discard_not_seen", {31'd0, instr_out == 32'hDEAD_BEEF}, 32'd0);

    // PC wraps from the top of the address space.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, mem_word(32'hFFFF_FFFC));
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    finish_cycle();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, mem_word(32'h0));
    check("wrap_addr1", imem_addr, 32'h0000_0000);
    finish_cycle();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(99) < 2), ($urandom_range(99) < 30), ($urandom_range(99) < 8),
            $urandom, ($urandom_range(99) < 70), $urandom);
      finish_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
